clkdiv_sel_ctrl: RTL

- Shares one clock divider between two requesters, each wanting its own division ratio.
- Arbitrates the two requesters round-robin and drives the divider's `Sel` and reset.
- Applies a ratio change only through a safe sequence (wait for divider output low, pulse divider reset, update `Sel`), so no runt pulse reaches downstream logic.
- Sits between the requesting control blocks and the clock divider instance.

---
 rtl/clkdiv_ctrl_pkg.sv | 20 ++
 rtl/clkdiv_rr_arb.sv | 33 +++
 rtl/clkdiv_sel_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_ctrl_pkg.sv
// Shared types and constants for the clock-divider select controller.
package clkdiv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_LOW,
    ST_DRESET,
    ST_OWNED
  } state_e;

  localparam logic [1:0] SEL_DIV2  = 2'b00;
  localparam logic [1:0] SEL_DIV4  = 2'b01;
  localparam logic [1:0] SEL_DIV8  = 2'b10;
  localparam logic [1:0] SEL_DIV16 = 2'b11;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/clkdiv_rr_arb.sv
// Two-way round-robin arbiter: combinational winner, registered priority pointer.
module clkdiv_rr_arb
  import clkdiv_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic advance,
  input  logic owner,
  output logic winner
);

  logic ptr_q, ptr_d;

  // On release or preemption, priority passes to the requester that did not own.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ~owner;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= REQ_A;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    winner = ptr_q;
    if (req_a && !req_b)      winner = REQ_A;
    else if (req_b && !req_a) winner = REQ_B;
  end

endmodule

// File: rtl/clkdiv_sel_ctrl.sv
// Arbitrates two requesters onto one clock divider and switches its ratio glitch-free.
// Optional PREEMPT_EN: owner is preempted after MAX_HOLD cycles of a waiting rival.
module clkdiv_sel_ctrl
  import clkdiv_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 2,
  parameter int WAIT_TIMEOUT = 16,
  parameter int MAX_HOLD     = 64
) (
  input  logic       Clock_in,
  input  logic       Reset,
  input  logic       Req_a,
  input  logic [1:0] Sel_a,
  input  logic       Req_b,
  input  logic [1:0] Sel_b,
  input  logic       Div_clk,
  output logic       Gnt_a,
  output logic       Gnt_b,
  output logic [1:0] Div_sel,
  output logic       Div_reset,
  output logic       Busy
);

  if (RST_CYCLES < 1 || WAIT_TIMEOUT < 1 || MAX_HOLD < 1) begin : g_bad_param
    $error("clkdiv_sel_ctrl: RST_CYCLES, WAIT_TIMEOUT and MAX_HOLD must be >= 1");
  end

  localparam int CNT_MAX = (WAIT_TIMEOUT > RST_CYCLES) ? WAIT_TIMEOUT : RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_TIMEOUT - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);

  // Req/Gnt: a requester raises Req and holds it; Gnt rises once the divider runs
  // at its ratio, and falls the edge after Req is sampled low.
  state_e        state_q, state_d;
  logic [1:0]    div_sel_q, div_sel_d;
  logic [1:0]    tgt_sel_q, tgt_sel_d;
  logic          div_reset_q, div_reset_d;
  logic          busy_q, busy_d;
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          owner_q, owner_d;
  logic          low_seen_q, low_seen_d;
  logic [CW-1:0] seq_cnt_q, seq_cnt_d;
  logic          winner, advance;
  logic          req_own, req_oth;

`ifdef PREEMPT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  logic [HCW-1:0] own_cnt_q, own_cnt_d;
`endif

  clkdiv_rr_arb u_arb (
    .clk     (Clock_in),
    .rst_n   (Reset),
    .req_a   (Req_a),
    .req_b   (Req_b),
    .advance (advance),
    .owner   (owner_q),
    .winner  (winner)
  );

  assign req_own = (owner_q == REQ_B) ? Req_b : Req_a;
  assign req_oth = (owner_q == REQ_B) ? Req_a : Req_b;

  always_comb begin
    state_d     = state_q;
    div_sel_d   = div_sel_q;
    tgt_sel_d   = tgt_sel_q;
    div_reset_d = div_reset_q;
    busy_d      = busy_q;
    gnt_a_d     = gnt_a_q;
    gnt_b_d     = gnt_b_q;
    owner_d     = owner_q;
    low_seen_d  = 1'b0;
    seq_cnt_d   = '0;
    advance     = 1'b0;
`ifdef PREEMPT_EN
    own_cnt_d   = '0;
`endif
    unique case (state_q)
      ST_INIT: begin
        state_d     = ST_IDLE;
        div_reset_d = 1'b0;
        busy_d      = 1'b0;
      end
      ST_IDLE: begin
        if (Req_a || Req_b) begin
          owner_d   = winner;
          tgt_sel_d = (winner == REQ_B) ? Sel_b : Sel_a;
          if (tgt_sel_d == div_sel_q) begin
            state_d = ST_OWNED;
          end else begin
            state_d = ST_WAIT_LOW;
            busy_d  = 1'b1;
          end
        end
      end
      ST_WAIT_LOW: begin
        // Div_clk is only trusted once registered; a low seen here is acted on next edge.
        low_seen_d = low_seen_q | ~Div_clk;
        seq_cnt_d  = seq_cnt_q + 1'b1;
        if (low_seen_q || seq_cnt_q == WAIT_LAST) begin
          state_d     = ST_DRESET;
          div_reset_d = 1'b1;
          div_sel_d   = tgt_sel_q;
          seq_cnt_d   = '0;
        end
      end
      ST_DRESET: begin
        seq_cnt_d = seq_cnt_q + 1'b1;
        if (seq_cnt_q == RST_LAST) begin
          div_reset_d = 1'b0;
          busy_d      = 1'b0;
          seq_cnt_d   = '0;
          if (req_own) begin
            state_d = ST_OWNED;
            gnt_a_d = (owner_q == REQ_A);
            gnt_b_d = (owner_q == REQ_B);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OWNED: begin
        if (!(gnt_a_q || gnt_b_q)) begin
          if (req_own) begin
            gnt_a_d = (owner_q == REQ_A);
            gnt_b_d = (owner_q == REQ_B);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!req_own) begin
          gnt_a_d = 1'b0;
          gnt_b_d = 1'b0;
          state_d = ST_IDLE;
          advance = 1'b1;
        end
`ifdef PREEMPT_EN
        else if (req_oth) begin
          own_cnt_d = own_cnt_q + 1'b1;
          if (own_cnt_q == HOLD_LAST) begin
            gnt_a_d   = 1'b0;
            gnt_b_d   = 1'b0;
            state_d   = ST_IDLE;
            advance   = 1'b1;
            own_cnt_d = '0;
          end
        end
`endif
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge Clock_in) begin
    if (!Reset) begin
      state_q     <= ST_INIT;
      div_sel_q   <= SEL_DIV2;
      tgt_sel_q   <= SEL_DIV2;
      div_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      owner_q     <= REQ_A;
      low_seen_q  <= 1'b0;
      seq_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      div_sel_q   <= div_sel_d;
      tgt_sel_q   <= tgt_sel_d;
      div_reset_q <= div_reset_d;
      busy_q      <= busy_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      owner_q     <= owner_d;
      low_seen_q  <= low_seen_d;
      seq_cnt_q   <= seq_cnt_d;
    end
  end

`ifdef PREEMPT_EN
  always_ff @(posedge Clock_in) begin
    if (!Reset) own_cnt_q <= '0;
    else        own_cnt_q <= own_cnt_d;
  end
`else
  wire unused_oth = req_oth;
`endif

  assign Gnt_a     = gnt_a_q;
  assign Gnt_b     = gnt_b_q;
  assign Div_sel   = div_sel_q;
  assign Div_reset = div_reset_q;
  assign Busy      = busy_q;

endmodule
